// File: rtl/sa_result_writeback.sv
// sa_result_writeback: snapshots the systolic accumulator matrix, requantizes it to 8 bits
// and drains it into SRAM as one packed row per cycle.
module sa_result_writeback #(
    parameter int N      = 8,
    parameter int ACC_W  = 20,
    parameter int OUT_W  = 8,
    parameter int ADDR_W = 12
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [ADDR_W-1:0]                   base_addr,
    input  logic [4:0]                          shift,
    input  logic [N-1:0][N-1:0][ACC_W-1:0]      acc_in,
    output logic                                wsbn,
    output logic [ADDR_W-1:0]                   waddr,
    output logic [63:0]                         wdata,
    output logic                                busy,
    output logic                                done
);
    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam logic [4:0] SMAX = 5'(ACC_W - 1);
    localparam logic signed [ACC_W:0] QMAX = (ACC_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [ACC_W:0] QMIN = -QMAX - 1;

    typedef enum logic [1:0] {IDLE, WRITE, FIN} state_t;

    state_t                            state_q;
    logic [N-1:0][N-1:0][ACC_W-1:0]    snap_q;
    logic [ADDR_W-1:0]                 base_q, waddr_q;
    logic [4:0]                        shift_q;
    logic [RW-1:0]                     row_q;
    logic [63:0]                       wdata_q, word_d;
    logic                              wsbn_q, busy_q, done_q;

    // One extra bit of headroom keeps the rounding add from overflowing.
    function automatic logic [OUT_W-1:0] requant(input logic [ACC_W-1:0] v, input logic [4:0] s);
        logic signed [ACC_W:0] x, half;
        x = $signed({v[ACC_W-1], v});
        half = (s == 5'd0) ? '0 : $signed((ACC_W+1)'(1) << (s - 5'd1));
        x = (x + half) >>> s;
        return (x > QMAX) ? QMAX[OUT_W-1:0] : (x < QMIN) ? QMIN[OUT_W-1:0] : x[OUT_W-1:0];
    endfunction

    always_comb begin
        word_d = '0;
        for (int c = 0; c < N; c++)
            word_d[c*OUT_W +: OUT_W] = requant(snap_q[row_q][c], shift_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            snap_q  <= '0;
            base_q  <= '0;
            shift_q <= '0;
            row_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            wsbn_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            wsbn_q <= state_q != WRITE;
            busy_q <= state_q == WRITE;
            done_q <= state_q == FIN;
            case (state_q)
                IDLE: if (start) begin
                    snap_q  <= acc_in;
                    base_q  <= base_addr;
                    shift_q <= (shift > SMAX) ? SMAX : shift;
                    row_q   <= '0;
                    state_q <= WRITE;
                end
                WRITE: begin
                    waddr_q <= base_q + ADDR_W'(row_q);
                    wdata_q <= word_d;
                    row_q   <= row_q + 1'b1;
                    if (row_q == RW'(N - 1)) state_q <= FIN;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wsbn  = wsbn_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign busy  = busy_q;
    assign done  = done_q;
endmodule

// File: tb/tb_sa_result_writeback.sv
// tb_sa_result_writeback: random and directed writebacks checked against an integer model
// of requantization, packing and write timing.
module tb_sa_result_writeback;
    localparam int N = 8;
    localparam int ACC_W = 20;

    logic                           clk = 1'b0;
    logic                           rst_n = 1'b0;
    logic                           start = 1'b0;
    logic [11:0]                    base_addr = '0;
    logic [4:0]                     shift = '0;
    logic [N-1:0][N-1:0][ACC_W-1:0] acc_in = '0;
    logic                           wsbn, busy, done;
    logic [11:0]                    waddr;
    logic [63:0]                    wdata;

    int m_acc [N][N];
    int n_cmp = 0;
    int n_bad = 0;

    sa_result_writeback dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .shift(shift),
        .acc_in(acc_in), .wsbn(wsbn), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] quant(input int v, input int s);
        int ss, t;
        ss = (s > 19) ? 19 : s;
        t = (ss == 0) ? v : (v + (1 << (ss - 1))) >>> ss;
        t = (t > 127) ? 127 : (t < -128) ? -128 : t;
        return 8'(t);
    endfunction

    function automatic logic [63:0] row_word(input int r, input int s);
        logic [63:0] w = '0;
        for (int c = 0; c < N; c++) w[c*8 +: 8] = quant(m_acc[r][c], s);
        return w;
    endfunction

    function automatic int rnd_acc();
        logic [ACC_W-1:0] tmp;
        tmp = ACC_W'($urandom);
        return ($urandom_range(1) == 1) ? int'($signed(tmp)) : int'($urandom_range(4000)) - 2000;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_wsbn"}, 64'(wsbn), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    // start_k: raise start after the k-th write is seen; rst_k: pull reset at the k-th write.
    task automatic run_pass(input logic [11:0] base, input int sh, input bit scramble,
                            input int start_k, input int rst_k);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) acc_in[r][c] = ACC_W'(m_acc[r][c]);
        base_addr = base;
        shift = 5'(sh);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_idle("accept");
        if (scramble)
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) acc_in[r][c] = ACC_W'($urandom);
        for (int k = 1; k <= N; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == rst_k) begin
                rst_n = 1'b0;
                #1;
                check_idle("rst_async");
                @(negedge clk);
                rst_n = 1'b1;
                repeat (N + 3) begin
                    @(negedge clk);
                    check_idle("post_rst");
                end
                return;
            end
            check("w_wsbn", 64'(wsbn), 64'd0);
            check("w_busy", 64'(busy), 64'd1);
            check("w_done", 64'(done), 64'd0);
            check("w_addr", 64'(waddr), 64'(12'(base + 12'(k - 1))));
            check("w_data", wdata, row_word(k - 1, sh));
            if (k == start_k) start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        check("fin_done", 64'(done), 64'd1);
        check("fin_wsbn", 64'(wsbn), 64'd1);
        check("fin_busy", 64'(busy), 64'd0);
        check("fin_addr_hold", 64'(waddr), 64'(12'(base + 12'(N - 1))));
        repeat (3) begin
            @(negedge clk);
            check_idle("after");
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_idle("rst");
        check("rst_wdata", wdata, 64'd0);
        check("rst_waddr", 64'(waddr), 64'd0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_idle("idle");
            check("idle_wdata", wdata, 64'd0);
        end

        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) m_acc[r][c] = r * 8 + c;
        run_pass(12'h100, 0, 1'b0, 0, 0);

        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) m_acc[r][c] = rnd_acc();
        m_acc[0][0] = 24; m_acc[0][1] = 23; m_acc[0][2] = -24; m_acc[0][3] = 5000;
        m_acc[0][4] = -5000; m_acc[0][5] = -8; m_acc[0][6] = 7; m_acc[0][7] = -9;
        run_pass(12'h200, 4, 1'b0, 0, 0);
        run_pass(12'h300, 25, 1'b0, 0, 0);
        run_pass(12'h310, 19, 1'b0, 0, 0);

        run_pass(12'hFFE, $urandom_range(12), 1'b1, 0, 0);
        run_pass(12'h040, 2, 1'b0, 3, 0);
        run_pass(12'h050, 1, 1'b0, N, 0);
        run_pass(12'h060, 3, 1'b0, 0, 5);
        run_pass(12'h070, 6, 1'b0, 0, 0);

        repeat (12) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) m_acc[r][c] = rnd_acc();
            run_pass(12'($urandom), $urandom_range(31), 1'($urandom), 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sa_result_writeback.md
Name: sa_result_writeback

Overview:
- Drains the N x N accumulator matrix of the systolic array back into the 4K x 64b SRAM after a matmul completes. This is the write-side counterpart of the operand fetch path.
- On a start pulse, normally tied to the array's done, it snapshots all accumulators.
- Each 20-bit value is requantized to 8 bits: signed arithmetic shift, round, saturate.
- Each row is packed into one 64-bit word and written with an active-low write strobe, one row per cycle.

Parameters:
- N, 8, array dimension; N*OUT_W must be <= 64.
- ACC_W, 20, accumulator width, signed two's complement.
- OUT_W, 8, quantized element width, signed.
- ADDR_W, 12, SRAM address width.

Ports:
- clk  input  1  clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin writeback.
- base_addr  input  ADDR_W  SRAM address of row 0.
- shift  input  5  right-shift amount for requantization; values above 19 are treated as 19.
- acc_in  input  [N-1:0][N-1:0][ACC_W-1:0]  accumulator matrix, indexed [row][col].
- wsbn  output  1  SRAM write strobe, active low.
- waddr  output  ADDR_W  SRAM write address.
- wdata  output  64  SRAM write data.
- busy  output  1  high from the cycle after start is accepted through the last write.
- done  output  1  one-cycle pulse after the final write.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - wsbn=1, waddr=0, wdata=0, busy=0, done=0.
  - FSM returns to IDLE, row counter and snapshot buffer cleared.
  - Reset asserted mid-writeback aborts immediately; rows already written stay in SRAM and no done pulse is issued.
- FSM states: IDLE, WRITE, FIN.
  - IDLE: when start=1 at an edge, latch acc_in, base_addr and clamped shift into internal registers, set row=0, go to WRITE.
  - WRITE: outputs are registered; each cycle present wsbn=0, waddr=base+row, wdata=pack(row), then increment row. After row N-1 is presented, go to FIN.
  - FIN: wsbn=1, busy=0, done=1 for exactly one cycle, then return to IDLE.
- Timing, with start sampled at edge E:
  - Row r appears on the outputs after edge E+1+r.
  - busy=1 over the same N cycles.
  - done=1 after edge E+N+1.
  - Total latency from start to done is N+1 cycles.
- Start handling:
  - start while busy or in FIN is ignored; it is neither queued nor allowed to restart.
  - acc_in changes after the start edge have no effect because data comes from the snapshot.
- Address arithmetic: base+row wraps modulo 2^ADDR_W (base=4095, row 1 gives waddr 0).
- Requantization per element v (signed ACC_W), with s = clamped shift:
  - If s>0: t = (v + 2^(s-1)) >>> s, computed at ACC_W+1 bits so the rounding add cannot overflow.
  - If s=0: t = v.
  - Saturate t to [-128, 127].
- Packing:
  - Element [row][c] occupies wdata[8c+7:8c].
  - Bits above N*OUT_W are 0.
- Write-inactive state: when wsbn=1, waddr and wdata hold their last values. The SRAM ignores them.

Test Plan:
- Reset/idle: hold rst_n=0 for 2 cycles, then release with no start.
  - wsbn=1, busy=0, done=0, wdata=0 throughout.
- Basic writeback: N=8, base=0x100, shift=0, acc[r][c]=r*8+c.
  - 8 consecutive wsbn=0 cycles at addresses 0x100..0x107.
  - Row 0 wdata=0x0706050403020100.
  - done pulses exactly 9 cycles after the start edge.
- Rounding and saturation: shift=4, with these elements:
  - acc 24 gives 2 (24+8=32, 32>>>4=2).
  - acc 23 gives 1 (23+8=31, 31>>>4=1).
  - acc -24 gives -1, i.e. 0xFF (-24+8=-16, -16>>>4=-1).
  - acc 5000 saturates to 0x7F.
  - acc -5000 saturates to 0x80.
  - Also shift=25 gives the same outputs as shift=19.
- Wrap and snapshot: base=0xFFE.
  - waddr sequence is FFE, FFF, 000, ..., 005.
  - Randomizing acc_in one cycle after start leaves wdata matching the snapshot taken at start.
- Start during busy: pulse start at write cycle 3.
  - No restart and no extra writes; exactly one done pulse.
  - A new start after done produces a full second pass.
- Reset mid-operation: assert rst_n=0 during row 4.
  - wsbn=1 and busy=0 immediately (asynchronous).
  - No done pulse; next start behaves normally.
